lfsr_burst_arbiter: RTL
=======================

Name: lfsr_burst_arbiter

Overview:
Shares one 4-bit maximal-length LFSR between two requesters (A, B).
Each requester asks for a burst of N pseudo-random nibbles from its own seed. The block arbitrates round-robin, seeds the LFSR, and steps it under a valid/ready handshake to one consumer. It signals burst completion to the owner.
It sits between the test/crypto-lite requesters and the shared LFSR datapath, replacing ad-hoc sel/seed driving.

Parameters:
LEN_W, 4, width of burst-length inputs; length 0 means 2**LEN_W words.
SAFE_SEED, 4'b1111, value loaded in place of an all-zero seed (lock-up avoidance); also the reset value of the LFSR.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_a  in  1  requester A burst request; level, held until done_a
seed_a  in  4  A seed, sampled at grant
len_a  in  LEN_W  A burst length, sampled at grant
req_b  in  1  requester B burst request
seed_b  in  4  B seed, sampled at grant
len_b  in  LEN_W  B burst length, sampled at grant
gnt_a  out  1  A owns the LFSR (LOAD through DONE)
gnt_b  out  1  B owns the LFSR
w  out  4  current LFSR word
out_valid  out  1  w valid (RUN state only)
out_ready  in  1  consumer accepts w this cycle
out_owner  out  1  0 = A, 1 = B; meaningful while out_valid
done_a  out  1  one-cycle pulse, A burst complete
done_b  out  1  one-cycle pulse, B burst complete
busy  out  1  state != IDLE

Behaviour:
- Reset, async: state=IDLE; gnt_a/b, out_valid, done_a/b, busy, out_owner=0; w=SAFE_SEED; cnt=0; last_grant=B, so A wins the first tie.
- LFSR step, polynomial x^4+x^3+1: w_next = {w[2:0], w[3]^w[2]}. Period 15. From 1111: 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: if any req, grant per round-robin. If both are asserted, grant the one != last_grant; otherwise grant the single requester.
  - At that edge: gnt_x=1, latch seed/len, last_grant<=x, owner<=x, go to LOAD. No request: stay in IDLE, w holds.
- LOAD, 1 cycle: w<=(seed==0 ? SAFE_SEED : seed); cnt<=(len==0 ? 2**LEN_W : len); go to RUN.
- RUN: out_valid=1, w = current word; the first word is the seed itself.
  - On an edge with out_ready=1: w steps, cnt decrements. If cnt==1, go to DONE.
  - out_ready=0: w, cnt and state hold (stall of any length).
- DONE, 1 cycle: out_valid=0, done_x=1, gnt_x still 1; next edge: gnt_x=0, go to IDLE.
- Latency: req seen in IDLE at edge k; first out_valid in the cycle after edge k+1. Minimum gap between bursts is 1 IDLE cycle after DONE.
- After DONE the LFSR keeps its last stepped value; it is not reset between bursts.
- A request deasserted mid-burst is ignored; the burst runs to completion. Seed/len changes after grant are ignored.
- Requester still asserting req after its done is eligible again, but loses a tie to the other requester.
- Reset mid-burst: immediate return to reset values. No done pulse.
- gnt_a and gnt_b are never high together. done_x is only ever asserted with gnt_x.

Test Plan:
- Reset then idle: reset 1→0, no req → busy=0, out_valid=0, w=1111 indefinitely; asserting reset mid-RUN forces all outputs to 0 and w=1111 immediately.
- Single A burst: seed_a=1111, len_a=4, out_ready=1 → gnt_a, then out_valid for 4 cycles with w=1111, 1110, 1100, 1000; done_a one cycle; final w=0001.
- Zero seed and zero length: seed_b=0000, len_b=0 → 16 words starting 1111, wrapping after 15 (word 16 = 1111); done_b pulses.
- Simultaneous req_a=req_b=1 from reset: A granted first (seed 0011, len 2 → 0011, 0110), then B (seed 1010, len 3 → 1010, 0101, 1011). With both held, the next grant alternates back to A.
- Backpressure: A seed 1001, len 3; out_ready toggles 1,0,0,1,0,1 → w holds across stalls; accepted sequence is exactly 1001, 0011, 0110; done_a follows the 3rd accept.
- Mid-burst perturbation: drop req_a and change seed_a/len_a during RUN → burst completes with the originally latched values; gnt_a/gnt_b never overlap.

Source files
------------

// File: rtl/lfsr_burst_arbiter.sv
// Round-robin arbiter that lends one x^4+x^3+1 LFSR to two burst requesters.
// Words are streamed to one consumer under valid/ready, and completion is pulsed back to the owner.
module lfsr_burst_arbiter #(
    parameter int         LEN_W     = 4,
    parameter logic [3:0] SAFE_SEED = 4'b1111
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_a_i,
    input  logic [3:0]       seed_a_i,
    input  logic [LEN_W-1:0] len_a_i,
    input  logic             req_b_i,
    input  logic [3:0]       seed_b_i,
    input  logic [LEN_W-1:0] len_b_i,
    output logic             gnt_a_o,
    output logic             gnt_b_o,
    output logic [3:0]       w_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_owner_o,
    output logic             done_a_o,
    output logic             done_b_o,
    output logic             busy_o
);

    // state | meaning
    // IDLE  | no owner, LFSR holds its last value
    // LOAD  | seed and word count loaded from the granted requester
    // RUN   | words offered to the consumer, step on each accept
    // DONE  | one-cycle completion pulse to the owner
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

    localparam logic [LEN_W:0] CNT_FULL = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] CNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             owner_q;
    logic             last_grant_q;
    logic [3:0]       seed_q;
    logic [LEN_W-1:0] len_q;
    logic [3:0]       w_q;
    logic [LEN_W:0]   cnt_q;

    logic             any_req;
    logic             pick_b;
    logic             accept;
    logic [3:0]       w_step;

    assign any_req = req_a_i | req_b_i;
    // On a tie the requester that did not own the previous burst wins.
    assign pick_b  = req_b_i & (~req_a_i | ~last_grant_q);
    assign accept  = (state_q == RUN) & out_ready_i;
    assign w_step  = {w_q[2:0], w_q[3] ^ w_q[2]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (accept && cnt_q == CNT_ONE) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != IDLE);
        out_valid_o = (state_q == RUN);
        gnt_a_o     = busy_o & ~owner_q;
        gnt_b_o     = busy_o & owner_q;
        done_a_o    = (state_q == DONE) & ~owner_q;
        done_b_o    = (state_q == DONE) & owner_q;
        out_owner_o = owner_q;
        w_o         = w_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            seed_q       <= 4'd0;
            len_q        <= '0;
            w_q          <= SAFE_SEED;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q      <= pick_b;
                        last_grant_q <= pick_b;
                        seed_q       <= pick_b ? seed_b_i : seed_a_i;
                        len_q        <= pick_b ? len_b_i : len_a_i;
                    end
                end
                LOAD: begin
                    // An all-zero seed would lock the LFSR up.
                    w_q   <= (seed_q == 4'd0) ? SAFE_SEED : seed_q;
                    cnt_q <= (len_q == '0) ? CNT_FULL : {1'b0, len_q};
                end
                RUN: begin
                    if (accept) begin
                        w_q   <= w_step;
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
